ws_conv_sequencer: RTL and testbench



---
 rtl/ws_conv_sequencer_pkg.sv | 35 +++
 rtl/ws_raster_counter.sv | 54 +++++
 rtl/ws_conv_sequencer.sv | 178 +++++++++++++++++
 tb/tb_ws_conv_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ws_conv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ws_conv_pkg
// Brief   : Shared state encoding, row type and output-size helpers for the
//           weight-stationary conv sequencer and its activation fetch path.
// Revision: 1.0 - initial release
// ============================================================================
package ws_conv_pkg;

  localparam int WS_KERNEL_WIDTH = 3;
  localparam int WS_WEIGHT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } ws_seq_state_e;

  // One kernel row as delivered to the PE array, col 0 in the LSBs.
  typedef logic signed [WS_KERNEL_WIDTH-1:0][WS_WEIGHT_WIDTH-1:0] ws_weight_row_t;

  // Valid convolution, stride 1.
  function automatic int ws_out_dim(input int img, input int k);
    return img - k + 1;
  endfunction

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int ws_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ws_raster_counter.sv
`default_nettype none
// ============================================================================
// Module  : ws_raster_counter
// Brief   : Raster-order (x, y) output-position counter with clear, advance
//           and last-position flag.
// Revision: 1.0 - initial release
// ============================================================================
module ws_raster_counter
  import ws_conv_pkg::*;
#(
  parameter int OUT_W = 26,
  parameter int OUT_H = 26,
  parameter int XW    = ws_idx_w(OUT_W),
  parameter int YW    = ws_idx_w(OUT_H)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);

  localparam logic [XW-1:0] X_LAST = XW'(OUT_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(OUT_H - 1);

  logic w_x_last;
  logic w_y_last;

  assign w_x_last = (x_o == X_LAST);
  assign w_y_last = (y_o == Y_LAST);
  assign last_o   = w_x_last & w_y_last;

  // Advancing past the last position wraps to (0,0), ready for the next pass.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_o <= '0;
      y_o <= '0;
    end else if (clear_i) begin
      x_o <= '0;
      y_o <= '0;
    end else if (advance_i) begin
      if (w_x_last) begin
        x_o <= '0;
        y_o <= w_y_last ? '0 : y_o + 1'b1;
      end else begin
        x_o <= x_o + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ws_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ws_conv_sequencer
// Brief   : Sequences one conv pass: weight capture, row preload, raster
//           coordinate issue, pipeline drain, done pulse.
//           WS_CONV_SEQ_PERF_EN adds the stall_cnt_o performance counter.
// Revision: 1.0 - initial release
// ============================================================================
module ws_conv_sequencer
  import ws_conv_pkg::*;
#(
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 3,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int IMG_WIDTH     = 28,
  parameter int IMG_HEIGHT    = 28,
  parameter int DRAIN_CYCLES  = 4,
  localparam int OUT_W = ws_out_dim(IMG_WIDTH, KERNEL_WIDTH),
  localparam int OUT_H = ws_out_dim(IMG_HEIGHT, KERNEL_HEIGHT),
  localparam int XW    = ws_idx_w(OUT_W),
  localparam int YW    = ws_idx_w(OUT_H),
  localparam int RW    = ws_idx_w(KERNEL_HEIGHT),
  localparam int ROW_W = KERNEL_WIDTH * WEIGHT_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [KERNEL_HEIGHT*ROW_W-1:0] weight_i,
  output logic                          wload_valid_o,
  output logic [RW-1:0]                 wload_row_o,
  output logic [ROW_W-1:0]              wload_data_o,
  output logic                          act_valid_o,
  input  logic                          act_ready_i,
  output logic [XW-1:0]                 act_x_o,
  output logic [YW-1:0]                 act_y_o,
  output logic                          busy_o,
  output logic                          done_o
`ifdef WS_CONV_SEQ_PERF_EN
  ,
  output logic [31:0]                   stall_cnt_o
`endif
);

  localparam int            DW         = ws_idx_w(DRAIN_CYCLES);
  localparam logic [RW-1:0] ROW_LAST   = RW'(KERNEL_HEIGHT - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  ws_seq_state_e                  r_state;
  logic [KERNEL_HEIGHT*ROW_W-1:0] r_weights;
  logic [DW-1:0]                  r_drain;
  logic [RW-1:0]                  w_row_nxt;
  logic                           w_abort;
  logic                           w_accept;
  logic                           w_last;

  assign w_abort   = abort_i & (r_state != ST_IDLE);
  assign w_accept  = act_valid_o & act_ready_i;
  assign w_row_nxt = wload_row_o + 1'b1;

  ws_raster_counter #(
    .OUT_W (OUT_W),
    .OUT_H (OUT_H),
    .XW    (XW),
    .YW    (YW)
  ) u_raster (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (w_abort),
    .advance_i (w_accept),
    .x_o       (act_x_o),
    .y_o       (act_y_o),
    .last_o    (w_last)
  );

  // Abort outranks every transition, including the final handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_weights     <= '0;
      r_drain       <= '0;
      wload_valid_o <= 1'b0;
      wload_row_o   <= '0;
      wload_data_o  <= '0;
      act_valid_o   <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else if (w_abort) begin
      r_state       <= ST_IDLE;
      r_drain       <= '0;
      wload_valid_o <= 1'b0;
      wload_row_o   <= '0;
      wload_data_o  <= '0;
      act_valid_o   <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            r_weights     <= weight_i;
            r_state       <= ST_LOAD;
            busy_o        <= 1'b1;
            wload_valid_o <= 1'b1;
            wload_row_o   <= '0;
            wload_data_o  <= weight_i[ROW_W-1:0];
          end
        end
        ST_LOAD: begin
          if (wload_row_o == ROW_LAST) begin
            r_state       <= ST_STREAM;
            wload_valid_o <= 1'b0;
            wload_row_o   <= '0;
            wload_data_o  <= '0;
            act_valid_o   <= 1'b1;
          end else begin
            wload_row_o  <= w_row_nxt;
            wload_data_o <= r_weights[w_row_nxt*ROW_W +: ROW_W];
          end
        end
        ST_STREAM: begin
          if (w_accept && w_last) begin
            act_valid_o <= 1'b0;
            // The handshake cycle itself is the first of the drain cycles.
            if (DRAIN_CYCLES == 1) begin
              r_state <= ST_DONE;
              done_o  <= 1'b1;
            end else begin
              r_state <= ST_DRAIN;
              r_drain <= DW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (r_drain == DRAIN_LAST) begin
            r_state <= ST_DONE;
            r_drain <= '0;
            done_o  <= 1'b1;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: begin
          r_state       <= ST_IDLE;
          wload_valid_o <= 1'b0;
          act_valid_o   <= 1'b0;
          busy_o        <= 1'b0;
          done_o        <= 1'b0;
        end
      endcase
    end
  end

`ifdef WS_CONV_SEQ_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_IDLE) && start_i) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_STREAM) && act_valid_o && !act_ready_i &&
                 (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ws_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ws_conv_sequencer
// Brief   : Randomized self-checking bench for ws_conv_sequencer (5x5 image,
//           3x3 kernel, 4 drain cycles) against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ws_conv_sequencer;
  import ws_conv_pkg::*;

  localparam int KW   = 3;
  localparam int KH   = 3;
  localparam int WW   = 8;
  localparam int IMG  = 5;
  localparam int DRN  = 4;
  localparam int OW   = IMG - KW + 1;
  localparam int OH   = IMG - KH + 1;
  localparam int ROWW = KW * WW;
  localparam int WTOT = KH * ROWW;

  localparam int MODE_READY  = 0;
  localparam int MODE_RAND   = 1;
  localparam int MODE_STALL7 = 2;

  typedef struct {
    int x;
    int y;
  } coord_t;

  logic            clk_i;
  logic            rst_ni;
  logic            start_i;
  logic            abort_i;
  logic [WTOT-1:0] weight_i;
  logic            wload_valid_o;
  logic [1:0]      wload_row_o;
  logic [ROWW-1:0] wload_data_o;
  logic            act_valid_o;
  logic            act_ready_i;
  logic [1:0]      act_x_o;
  logic [1:0]      act_y_o;
  logic            busy_o;
  logic            done_o;
`ifdef WS_CONV_SEQ_PERF_EN
  logic [31:0]     stall_cnt_o;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  ws_conv_sequencer #(
    .KERNEL_WIDTH  (KW),
    .KERNEL_HEIGHT (KH),
    .WEIGHT_WIDTH  (WW),
    .IMG_WIDTH     (IMG),
    .IMG_HEIGHT    (IMG),
    .DRAIN_CYCLES  (DRN)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .weight_i      (weight_i),
    .wload_valid_o (wload_valid_o),
    .wload_row_o   (wload_row_o),
    .wload_data_o  (wload_data_o),
    .act_valid_o   (act_valid_o),
    .act_ready_i   (act_ready_i),
    .act_x_o       (act_x_o),
    .act_y_o       (act_y_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
`ifdef WS_CONV_SEQ_PERF_EN
    ,
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [WTOT-1:0] rand_w();
    logic [WTOT-1:0] v;
    v = '0;
    for (int i = 0; i < KH * KW; i++) v[i*WW +: WW] = WW'($urandom_range(0, 255));
    return v;
  endfunction

  // One pass: starts at an IDLE-cycle negedge, ends at the IDLE-cycle negedge
  // following done (or following an abort).
  task automatic run_pass(input logic [WTOT-1:0] w, input int mode, input int abort_at,
                          input bit hold_start);
    coord_t q[$];
    int     n_hs;
    int     cyc;
    int     stalls;
    bit     rdy;

    for (int y = 0; y < OH; y++)
      for (int x = 0; x < OW; x++) q.push_back('{x: x, y: y});

    start_i  = 1'b1;
    weight_i = w;
    @(negedge clk_i);
    if (!hold_start) start_i = 1'b0;
    weight_i = '0;

    for (int r = 0; r < KH; r++) begin
      check_eq("wload_valid", 64'(wload_valid_o), 64'(1));
      check_eq("wload_row", 64'(wload_row_o), 64'(r));
      check_eq("wload_data", 64'(wload_data_o), 64'(w[r*ROWW +: ROWW]));
      check_eq("busy_load", 64'(busy_o), 64'(1));
      check_eq("act_valid_load", 64'(act_valid_o), 64'(0));
      @(negedge clk_i);
    end

    n_hs   = 0;
    cyc    = 0;
    stalls = 0;
    while (q.size() > 0) begin
      if (cyc > 400) begin
        check_eq("stream_timeout", 64'(q.size()), 64'(0));
        break;
      end
      check_eq("act_valid", 64'(act_valid_o), 64'(1));
      check_eq("act_x", 64'(act_x_o), 64'(q[0].x));
      check_eq("act_y", 64'(act_y_o), 64'(q[0].y));
      check_eq("wload_valid_stream", 64'(wload_valid_o), 64'(0));
      if (n_hs == abort_at) begin
        abort_i     = 1'b1;
        act_ready_i = 1'b1;
        @(negedge clk_i);
        abort_i     = 1'b0;
        act_ready_i = 1'b0;
        check_eq("abort_busy", 64'(busy_o), 64'(0));
        check_eq("abort_valid", 64'(act_valid_o), 64'(0));
        check_eq("abort_x", 64'(act_x_o), 64'(0));
        check_eq("abort_y", 64'(act_y_o), 64'(0));
        for (int k = 0; k < DRN + 3; k++) begin
          check_eq("abort_no_done", 64'(done_o), 64'(0));
          @(negedge clk_i);
        end
        return;
      end
      case (mode)
        MODE_READY: rdy = 1'b1;
        MODE_RAND:  rdy = 1'($urandom_range(0, 1));
        default:    rdy = (cyc >= 7);
      endcase
      act_ready_i = rdy;
      if (!rdy) stalls++;
      @(negedge clk_i);
      if (rdy) begin
        void'(q.pop_front());
        n_hs++;
      end
      cyc++;
    end
    act_ready_i = 1'b0;

    for (int k = 1; k < DRN; k++) begin
      check_eq("drain_valid", 64'(act_valid_o), 64'(0));
      check_eq("drain_done", 64'(done_o), 64'(0));
      check_eq("drain_busy", 64'(busy_o), 64'(1));
      @(negedge clk_i);
    end
    check_eq("done_pulse", 64'(done_o), 64'(1));
    check_eq("done_busy", 64'(busy_o), 64'(1));
`ifdef WS_CONV_SEQ_PERF_EN
    check_eq("stall_cnt", 64'(stall_cnt_o), 64'(stalls));
`endif
    @(negedge clk_i);
    check_eq("post_done", 64'(done_o), 64'(0));
    check_eq("post_busy", 64'(busy_o), 64'(0));
  endtask

  initial begin
    ws_weight_row_t row20;
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    act_ready_i = 1'b0;
    weight_i    = '0;
    repeat (3) @(negedge clk_i);

    check_eq("rst_busy", 64'(busy_o), 64'(0));
    check_eq("rst_done", 64'(done_o), 64'(0));
    check_eq("rst_act_valid", 64'(act_valid_o), 64'(0));
    check_eq("rst_wload_valid", 64'(wload_valid_o), 64'(0));
    check_eq("rst_xy", 64'({act_x_o, act_y_o}), 64'(0));
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_eq("idle_busy", 64'(busy_o), 64'(0));

    run_pass(rand_w(), MODE_READY, -1, 1'b0);
    run_pass(rand_w(), MODE_RAND, -1, 1'b0);
    run_pass(rand_w(), MODE_RAND, -1, 1'b0);

    row20 = {KW{8'sb00100000}};
    run_pass({KH{row20}}, MODE_RAND, -1, 1'b0);

    run_pass(rand_w(), MODE_READY, 4, 1'b0);
    run_pass(rand_w(), MODE_RAND, -1, 1'b0);

    run_pass(rand_w(), MODE_READY, -1, 1'b1);
    run_pass(rand_w(), MODE_STALL7, -1, 1'b0);

    // Asynchronous reset in the middle of STREAM.
    start_i     = 1'b1;
    weight_i    = rand_w();
    act_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (KH + 2) @(negedge clk_i);
    check_eq("pre_rst_x", 64'(act_x_o), 64'(2));
    check_eq("pre_rst_valid", 64'(act_valid_o), 64'(1));
    act_ready_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("arst_valid", 64'(act_valid_o), 64'(0));
    check_eq("arst_busy", 64'(busy_o), 64'(0));
    check_eq("arst_x", 64'(act_x_o), 64'(0));
    check_eq("arst_wdata", 64'(wload_data_o), 64'(0));
`ifdef WS_CONV_SEQ_PERF_EN
    check_eq("arst_stall", 64'(stall_cnt_o), 64'(0));
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_eq("post_rst_busy", 64'(busy_o), 64'(0));
    run_pass(rand_w(), MODE_RAND, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
